// File: rtl/usb2_ulpi_if.sv
// ULPI 8-bit SDR bus between the link (master) and the external PHY (slave).
interface usb2_ulpi_if;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_stp;

  modport master (
    input  ulpi_dir,
    input  ulpi_nxt,
    input  ulpi_data_in,
    output ulpi_data_out,
    output ulpi_data_oe,
    output ulpi_stp
  );

  modport slave (
    output ulpi_dir,
    output ulpi_nxt,
    output ulpi_data_in,
    input  ulpi_data_out,
    input  ulpi_data_oe,
    input  ulpi_stp
  );
endinterface

// File: rtl/usb2_ulpi.sv
// ULPI link layer: splits RX CMDs from packet bytes, forwards transmit handshake,
// and runs PHY register accesses including the Function Control write after reset.
module usb2_ulpi #(
  parameter logic [7:0]  FUNC_CTRL_INIT = 8'h41,
  parameter logic [15:0] INIT_DELAY     = 16'd60000
) (
  input  logic        phy_clk,
  input  logic        reset,
  usb2_ulpi_if.master ulpi,
  output logic        in_act,
  output logic [7:0]  in_byte,
  output logic        in_latch,
  output logic        out_cts,
  output logic        out_nxt,
  input  logic [7:0]  out_byte,
  input  logic        out_latch,
  input  logic        out_stp,
  input  logic [5:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_write,
  input  logic        reg_read,
  output logic [7:0]  reg_rdata,
  output logic        reg_done,
  output logic        phy_ready,
  output logic [1:0]  line_state,
  output logic [1:0]  vbus_state,
  output logic        rx_err
);

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_IDLE,
    ST_RX,
    ST_TX,
    ST_REG_W_CMD,
    ST_REG_W_DATA,
    ST_REG_W_STP,
    ST_REG_R_CMD,
    ST_REG_R_TURN,
    ST_REG_R_DATA
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        dir_1;

  logic        pend_valid;
  logic        pend_read;
  logic [5:0]  pend_addr;
  logic [7:0]  pend_wdata;

  // Operation currently on the bus; retry holds it for re-issue after an abort.
  logic        cur_read;
  logic        cur_internal;
  logic [5:0]  cur_addr;
  logic [7:0]  cur_wdata;
  logic        retry;

  logic        dir;
  logic        nxt;
  logic [7:0]  data;
  logic        rx_ok;
  logic        req;
  logic        pend_take;
  logic [7:0]  data_out;
  logic        stp;

  assign dir  = ulpi.ulpi_dir;
  assign nxt  = ulpi.ulpi_nxt;
  assign data = ulpi.ulpi_data_in;

  assign ulpi.ulpi_data_oe  = ~dir;
  assign ulpi.ulpi_data_out = data_out;
  assign ulpi.ulpi_stp      = stp;

  // Register read data shares the bus with RX CMDs, so it must not be decoded as one.
  assign rx_ok     = dir & dir_1 & (state != ST_REG_R_DATA);
  assign req       = reg_write | reg_read;
  assign pend_take = (state == ST_IDLE) & ~dir & ~out_latch & ~retry & pend_valid;

  always_comb begin
    data_out = 8'h00;
    stp      = 1'b0;
    out_nxt  = 1'b0;
    case (state)
      ST_TX: begin
        out_nxt = nxt & ~dir;
        if (out_stp) stp = ~dir;
        else         data_out = out_byte;
      end
      ST_REG_W_CMD:  data_out = {2'b10, cur_addr};
      ST_REG_W_DATA: data_out = cur_wdata;
      ST_REG_W_STP:  stp = 1'b1;
      ST_REG_R_CMD:  data_out = {2'b11, cur_addr};
      default: ;
    endcase
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state        <= ST_INIT_WAIT;
      cnt          <= 16'd0;
      dir_1        <= 1'b0;
      in_act       <= 1'b0;
      in_byte      <= 8'h00;
      in_latch     <= 1'b0;
      out_cts      <= 1'b0;
      reg_rdata    <= 8'h00;
      reg_done     <= 1'b0;
      phy_ready    <= 1'b0;
      line_state   <= 2'b00;
      vbus_state   <= 2'b00;
      rx_err       <= 1'b0;
      pend_valid   <= 1'b0;
      pend_read    <= 1'b0;
      pend_addr    <= 6'h00;
      pend_wdata   <= 8'h00;
      cur_read     <= 1'b0;
      cur_internal <= 1'b0;
      cur_addr     <= 6'h00;
      cur_wdata    <= 8'h00;
      retry        <= 1'b0;
    end else begin
      dir_1    <= dir;
      in_latch <= 1'b0;
      rx_err   <= 1'b0;
      reg_done <= 1'b0;
      out_cts  <= 1'b0;

      if (rx_ok) begin
        if (nxt) begin
          in_byte  <= data;
          in_latch <= 1'b1;
        end else begin
          line_state <= data[1:0];
          vbus_state <= data[3:2];
          in_act     <= data[4];
          rx_err     <= data[5] & data[4];
        end
      end else if (dir & ~dir_1 & nxt) begin
        in_act <= 1'b1;
      end else if (~dir & dir_1) begin
        in_act <= 1'b0;
      end

      if (req & (~pend_valid | pend_take)) begin
        pend_valid <= 1'b1;
        pend_read  <= ~reg_write;
        pend_addr  <= reg_addr;
        pend_wdata <= reg_wdata;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_INIT_WAIT: begin
          if (cnt == INIT_DELAY - 16'd1) begin
            cur_read     <= 1'b0;
            cur_internal <= 1'b1;
            cur_addr     <= 6'h04;
            cur_wdata    <= FUNC_CTRL_INIT;
            state        <= ST_REG_W_CMD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (dir) begin
            state <= ST_RX;
          end else if (out_latch) begin
            state <= ST_TX;
          end else if (retry) begin
            retry <= 1'b0;
            state <= cur_read ? ST_REG_R_CMD : ST_REG_W_CMD;
          end else if (pend_valid) begin
            cur_read     <= pend_read;
            cur_internal <= 1'b0;
            cur_addr     <= pend_addr;
            cur_wdata    <= pend_wdata;
            state        <= pend_read ? ST_REG_R_CMD : ST_REG_W_CMD;
          end else begin
            out_cts <= ~dir_1;
          end
        end
        ST_RX: begin
          if (~dir & ~dir_1) state <= ST_IDLE;
        end
        ST_TX: begin
          if (dir)          state <= ST_RX;
          else if (out_stp) state <= ST_IDLE;
        end
        ST_REG_W_CMD: begin
          if (dir) begin
            retry <= 1'b1;
            state <= ST_RX;
          end else if (nxt) begin
            state <= ST_REG_W_DATA;
          end
        end
        ST_REG_W_DATA: begin
          if (dir) begin
            retry <= 1'b1;
            state <= ST_RX;
          end else if (nxt) begin
            state <= ST_REG_W_STP;
          end
        end
        ST_REG_W_STP: begin
          reg_done <= ~cur_internal;
          if (cur_internal) phy_ready <= 1'b1;
          state <= ST_IDLE;
        end
        ST_REG_R_CMD: begin
          if (dir) begin
            retry <= 1'b1;
            state <= ST_RX;
          end else if (nxt) begin
            state <= ST_REG_R_TURN;
          end
        end
        ST_REG_R_TURN: begin
          // dir rising with nxt means the PHY took the bus for a received packet.
          if (dir & nxt) begin
            retry <= 1'b1;
            state <= ST_RX;
          end else begin
            state <= ST_REG_R_DATA;
          end
        end
        ST_REG_R_DATA: begin
          reg_rdata <= data;
          reg_done  <= 1'b1;
          state     <= ST_RX;
        end
        default: state <= ST_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ulpi.sv
// Directed bench for usb2_ulpi: init write, RX decode, TX forwarding,
// register read/write, deferral and abort handling, and reset during transmit.
module tb_usb2_ulpi;

  logic       phy_clk;
  logic       reset;
  logic       in_act;
  logic [7:0] in_byte;
  logic       in_latch;
  logic       out_cts;
  logic       out_nxt;
  logic [7:0] out_byte;
  logic       out_latch;
  logic       out_stp;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata;
  logic       reg_done;
  logic       phy_ready;
  logic [1:0] line_state;
  logic [1:0] vbus_state;
  logic       rx_err;

  int check_count = 0;
  int error_count = 0;
  int done_count  = 0;
  int done_base;
  int init_cycles;

  usb2_ulpi_if bus ();

  usb2_ulpi dut (
    .phy_clk    (phy_clk),
    .reset      (reset),
    .ulpi       (bus.master),
    .in_act     (in_act),
    .in_byte    (in_byte),
    .in_latch   (in_latch),
    .out_cts    (out_cts),
    .out_nxt    (out_nxt),
    .out_byte   (out_byte),
    .out_latch  (out_latch),
    .out_stp    (out_stp),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_rdata  (reg_rdata),
    .reg_done   (reg_done),
    .phy_ready  (phy_ready),
    .line_state (line_state),
    .vbus_state (vbus_state),
    .rx_err     (rx_err)
  );

  initial phy_clk = 1'b0;
  always #8 phy_clk = ~phy_clk;

  always @(negedge phy_clk) if (reg_done === 1'b1) done_count++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dir, input logic nxt, input logic [7:0] data);
    bus.ulpi_dir     = dir;
    bus.ulpi_nxt     = nxt;
    bus.ulpi_data_in = data;
    #1;
  endtask

  task automatic tick();
    @(posedge phy_clk);
    #2;
  endtask

  initial begin
    logic [7:0] rx_bytes [3];
    rx_bytes = '{8'hA5, 8'h2D, 8'hF0};

    reset     = 1'b1;
    out_byte  = 8'h00;
    out_latch = 1'b0;
    out_stp   = 1'b0;
    reg_addr  = 6'h00;
    reg_wdata = 8'h00;
    reg_write = 1'b0;
    reg_read  = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #40;
    checkOutput("rst_in_act", in_act, 0);
    checkOutput("rst_cts", out_cts, 0);
    checkOutput("rst_ready", phy_ready, 0);
    checkOutput("rst_done", reg_done, 0);
    checkOutput("rst_stp", bus.ulpi_stp, 0);
    checkOutput("rst_data", bus.ulpi_data_out, 8'h00);
    checkOutput("rst_oe", bus.ulpi_data_oe, 1);

    // Init write: wait for the TX CMD 0x84 to appear after the power-up delay
    @(negedge phy_clk);
    reset = 1'b0;
    init_cycles = 0;
    for (int i = 1; i <= 60100; i++) begin
      tick();
      if (bus.ulpi_data_out === 8'h84) begin
        init_cycles = i;
        break;
      end
    end
    checkOutput("init_delay", init_cycles, 60000);
    checkOutput("init_cmd_wait", bus.ulpi_data_out, 8'h84);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("init_cmd", bus.ulpi_data_out, 8'h84);
    tick();
    checkOutput("init_data", bus.ulpi_data_out, 8'h41);
    tick();
    checkOutput("init_stp", bus.ulpi_stp, 1);
    checkOutput("init_stp_data", bus.ulpi_data_out, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("init_ready", phy_ready, 1);
    checkOutput("init_stp_low", bus.ulpi_stp, 0);
    checkOutput("init_no_done", done_count, 0);
    tick();
    checkOutput("idle_cts", out_cts, 1);

    // Receive: RX CMD then three packet bytes
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rx_oe_off", bus.ulpi_data_oe, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h15);
    tick();
    checkOutput("rx_in_act", in_act, 1);
    checkOutput("rx_line", line_state, 2'b01);
    checkOutput("rx_vbus", vbus_state, 2'b01);
    checkOutput("rx_cts", out_cts, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, rx_bytes[i]);
      tick();
      checkOutput("rx_latch", in_latch, 1);
      checkOutput("rx_byte", in_byte, rx_bytes[i]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rx_act_hold", in_act, 1);
    tick();
    checkOutput("rx_act_drop", in_act, 0);
    checkOutput("rx_latch_end", in_latch, 0);
    tick();
    tick();
    checkOutput("rx_back_idle", out_cts, 1);

    // RxError event then host-disconnect style RX CMD
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h31);
    tick();
    checkOutput("rxerr_pulse", rx_err, 1);
    checkOutput("rxerr_act", in_act, 1);
    applyStimulus(1'b1, 1'b0, 8'h22);
    tick();
    checkOutput("rxerr_clear", rx_err, 0);
    checkOutput("rxcmd_inact", in_act, 0);
    checkOutput("rxcmd_line", line_state, 2'b10);
    checkOutput("rxcmd_vbus", vbus_state, 2'b00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("rxerr_idle_cts", out_cts, 1);

    // Transmit 4B AA 55 then stop
    out_byte  = 8'h4B;
    out_latch = 1'b1;
    tick();
    out_latch = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("tx_b0", bus.ulpi_data_out, 8'h4B);
    checkOutput("tx_cts", out_cts, 0);
    checkOutput("tx_nxt", out_nxt, 1);
    tick();
    out_byte = 8'hAA;
    #1;
    checkOutput("tx_b1", bus.ulpi_data_out, 8'hAA);
    tick();
    out_byte = 8'h55;
    #1;
    checkOutput("tx_b2", bus.ulpi_data_out, 8'h55);
    tick();
    out_stp = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("tx_end_data", bus.ulpi_data_out, 8'h00);
    checkOutput("tx_stp", bus.ulpi_stp, 1);
    checkOutput("tx_nxt_low", out_nxt, 0);
    tick();
    out_stp = 1'b0;
    #1;
    checkOutput("tx_stp_once", bus.ulpi_stp, 0);

    // Register read of address 0x00 returning 0x24
    reg_addr = 6'h00;
    reg_read = 1'b1;
    tick();
    reg_read = 1'b0;
    done_base = done_count;
    tick();
    checkOutput("rd_cmd", bus.ulpi_data_out, 8'hC0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h24);
    tick();
    checkOutput("rd_data", reg_rdata, 8'h24);
    checkOutput("rd_done", reg_done, 1);
    checkOutput("rd_line_kept", line_state, 2'b10);
    checkOutput("rd_no_act", in_act, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("rd_done_pulse", reg_done, 0);
    tick();
    tick();
    checkOutput("rd_done_count", done_count - done_base, 1);

    // Write requested while the PHY owns the bus
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    reg_addr  = 6'h0A;
    reg_wdata = 8'h55;
    reg_write = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h05);
    tick();
    reg_write = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("defer_1", bus.ulpi_data_out, 8'h00);
    tick();
    checkOutput("defer_2", bus.ulpi_data_out, 8'h00);
    tick();
    checkOutput("defer_cmd", bus.ulpi_data_out, 8'h8A);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("defer_data", bus.ulpi_data_out, 8'h55);
    tick();
    checkOutput("defer_stp", bus.ulpi_stp, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("defer_done", reg_done, 1);

    // Write aborted in the data phase by an incoming packet, then re-issued
    reg_addr  = 6'h05;
    reg_wdata = 8'h3C;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    tick();
    checkOutput("abt_cmd", bus.ulpi_data_out, 8'h85);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("abt_data", bus.ulpi_data_out, 8'h3C);
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("abt_oe_off", bus.ulpi_data_oe, 0);
    tick();
    checkOutput("abt_in_act", in_act, 1);
    applyStimulus(1'b1, 1'b1, 8'h77);
    tick();
    checkOutput("abt_rx_byte", in_byte, 8'h77);
    checkOutput("abt_rx_latch", in_latch, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("abt_wait", bus.ulpi_data_out, 8'h00);
    checkOutput("abt_no_done", reg_done, 0);
    tick();
    checkOutput("abt_re_cmd", bus.ulpi_data_out, 8'h85);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("abt_re_data", bus.ulpi_data_out, 8'h3C);
    tick();
    checkOutput("abt_re_stp", bus.ulpi_stp, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("abt_re_done", reg_done, 1);
    tick();

    // Reset asserted in the middle of a transmit stop cycle
    out_byte  = 8'hC3;
    out_latch = 1'b1;
    tick();
    out_latch = 1'b0;
    out_stp   = 1'b1;
    #1;
    checkOutput("rst_tx_stp_pre", bus.ulpi_stp, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_tx_stp", bus.ulpi_stp, 0);
    checkOutput("rst_tx_data", bus.ulpi_data_out, 8'h00);
    checkOutput("rst_tx_cts", out_cts, 0);
    checkOutput("rst_tx_ready", phy_ready, 0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rst_tx_oe_dir", bus.ulpi_data_oe, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst_tx_oe", bus.ulpi_data_oe, 1);
    out_stp = 1'b0;
    @(negedge phy_clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rst_init_cts", out_cts, 0);
      checkOutput("rst_init_data", bus.ulpi_data_out, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
